stage4_forward_buffer: RTL and testbench

Parametrised forwarding unit for the memory/writeback boundary of the RV32IM pipeline. It holds a short history of retired register writes plus a capture register for returning load data, and serves NUM_PORTS stage-3 consumers (store data, address base, ...) with the youngest matching value. It raises a load-use stall when a consumer needs a stage-4 load whose data has not returned yet. It generalises the single-bit stage-3/stage-4 address-match mux to multiple ports, variable memory latency and stall-safe history.

---
 rtl/stage4_forward_buffer_pkg.sv | 18 +
 rtl/stage4_forward_buffer_history_cam.sv | 63 ++++++
 rtl/stage4_forward_buffer.sv | 111 +++++++++++
 tb/tb_stage4_forward_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage4_forward_buffer_pkg.sv
// Shared definitions for the stage-4 forwarding unit.
// This covers the default widths, the hard-wired zero register and the history entry layout.
package fwd_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // x0 is hard-wired to zero and must never be forwarded or recorded.
    localparam logic [REG_ADDR_W_DEF-1:0] ZERO_REG = '0;

    // One retired register write held in the history.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_W_DEF-1:0] addr;
        logic [XLEN_DEF-1:0]       data;
    } fwd_entry_t;

endpackage

// File: rtl/stage4_forward_buffer_history_cam.sv
// Circular history of retired register writes, with one youngest-match lookup per port.
// Entry widths follow fwd_pkg::fwd_entry_t.
module fwd_history_cam
    import fwd_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_wr_en,
    input  logic [REG_ADDR_W_DEF-1:0]           i_wr_addr,
    input  logic [XLEN_DEF-1:0]                 i_wr_data,
    input  logic                                i_flush,
    input  logic [NUM_PORTS*REG_ADDR_W_DEF-1:0] i_lookup_addr,
    output logic [NUM_PORTS-1:0]                o_hit,
    output logic [NUM_PORTS*XLEN_DEF-1:0]       o_data
);

    localparam int PTR_W = $clog2(DEPTH);

    fwd_entry_t       r_entry [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] w_idx;

    // Write pointer and entries: the flush clears everything and beats a write, and a wrap overwrites the oldest entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (i_flush) begin
            r_wp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i].valid <= 1'b0;
            end
        end else if (i_wr_en) begin
            r_entry[r_wp].valid <= 1'b1;
            r_entry[r_wp].addr  <= i_wr_addr;
            r_entry[r_wp].data  <= i_wr_data;
            r_wp                <= r_wp + 1'b1;
        end
    end

    // Youngest-match lookup: scan from the oldest slot (WP) to the youngest (WP-1) so that later matches override.
    always_comb begin
        o_hit  = '0;
        o_data = '0;
        w_idx  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = r_wp + PTR_W'(k);
                if (r_entry[w_idx].valid &&
                    (r_entry[w_idx].addr == i_lookup_addr[p*REG_ADDR_W_DEF +: REG_ADDR_W_DEF])) begin
                    o_hit[p]                           = 1'b1;
                    o_data[p*XLEN_DEF +: XLEN_DEF]     = r_entry[w_idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/stage4_forward_buffer.sv
// Forwarding unit at the memory/writeback boundary.
// It holds the load-data capture register, the per-port priority mux and the load-use stall.
module stage4_forward_buffer
    import fwd_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int NUM_PORTS  = 2,
    parameter int DEPTH      = 4
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            STALL,
    input  logic                            FLUSH,
    input  logic                            STAGE4_MEM_READ,
    input  logic [REG_ADDR_W-1:0]           STAGE4_REG_ADDR,
    input  logic                            STAGE4_DATA_VALID,
    input  logic [XLEN-1:0]                 STAGE4_DATA,
    input  logic                            WB_VALID,
    input  logic [REG_ADDR_W-1:0]           WB_REG_ADDR,
    input  logic [XLEN-1:0]                 WB_DATA,
    input  logic [NUM_PORTS-1:0]            REQ_VALID,
    input  logic [NUM_PORTS*REG_ADDR_W-1:0] REQ_REG_ADDR,
    output logic [NUM_PORTS-1:0]            FWD_HIT,
    output logic [NUM_PORTS*XLEN-1:0]       FWD_DATA,
    output logic                            LOAD_USE_STALL
);

    logic                      r_hold_valid;
    logic [XLEN-1:0]           r_hold_data;

    logic                      w_capture;
    logic                      w_hist_wr_en;
    logic                      w_ld_valid;
    logic [XLEN-1:0]           w_ld_data;
    logic [NUM_PORTS-1:0]      w_cam_hit;
    logic [NUM_PORTS*XLEN-1:0] w_cam_data;
    logic [NUM_PORTS-1:0]      w_hit;
    logic [NUM_PORTS*XLEN-1:0] w_data;
    logic [NUM_PORTS-1:0]      w_port_stall;
    logic [REG_ADDR_W-1:0]     w_addr;

    assign w_capture    = STAGE4_DATA_VALID && STAGE4_MEM_READ;
    assign w_hist_wr_en = WB_VALID && !STALL && !FLUSH &&
                          (WB_REG_ADDR != REG_ADDR_W'(ZERO_REG));

    // Returned load data: the direct path covers the return cycle, and the capture register covers later cycles.
    assign w_ld_valid = STAGE4_DATA_VALID || r_hold_valid;
    assign w_ld_data  = STAGE4_DATA_VALID ? STAGE4_DATA : r_hold_data;

    // Capture register: it keeps load data alive across stalls until writeback hands it to the history. A new capture beats a clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_capture) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= STAGE4_DATA;
        end else if ((WB_VALID && !STALL) || FLUSH) begin
            r_hold_valid <= 1'b0;
        end
    end

    fwd_history_cam #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH)
    ) u_history (
        .i_clk         (CLK),
        .i_rst_n       (RESET),
        .i_wr_en       (w_hist_wr_en),
        .i_wr_addr     (WB_REG_ADDR),
        .i_wr_data     (WB_DATA),
        .i_flush       (FLUSH),
        .i_lookup_addr (REQ_REG_ADDR),
        .o_hit         (w_cam_hit),
        .o_data        (w_cam_data)
    );

    // Per-port priority: a stage-4 load comes first, then the writeback bypass, then the youngest history entry.
    always_comb begin
        w_hit        = '0;
        w_data       = '0;
        w_port_stall = '0;
        w_addr       = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_addr = REQ_REG_ADDR[p*REG_ADDR_W +: REG_ADDR_W];
            if (REQ_VALID[p] && (w_addr != REG_ADDR_W'(ZERO_REG))) begin
                if (STAGE4_MEM_READ && (w_addr == STAGE4_REG_ADDR)) begin
                    if (w_ld_valid) begin
                        w_hit[p]                 = 1'b1;
                        w_data[p*XLEN +: XLEN]   = w_ld_data;
                    end else begin
                        w_port_stall[p]          = 1'b1;
                    end
                end else if (WB_VALID && (w_addr == WB_REG_ADDR)) begin
                    w_hit[p]                     = 1'b1;
                    w_data[p*XLEN +: XLEN]       = WB_DATA;
                end else if (w_cam_hit[p]) begin
                    w_hit[p]                     = 1'b1;
                    w_data[p*XLEN +: XLEN]       = w_cam_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // While reset is held, the combinational bypass paths must not leak onto the outputs.
    assign FWD_HIT        = RESET ? w_hit  : '0;
    assign FWD_DATA       = RESET ? w_data : '0;
    assign LOAD_USE_STALL = RESET && (|w_port_stall);

endmodule

// File: tb/tb_stage4_forward_buffer.sv
// Directed bench for stage4_forward_buffer.
// The driver pushes expected outputs and the monitor compares them on the falling edge.
module tb_stage4_forward_buffer;

  localparam int W = 1 + 2 + 64;  // {stall, hit[1:0], data port1, data port0}

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        FLUSH;
  logic        STAGE4_MEM_READ;
  logic [4:0]  STAGE4_REG_ADDR;
  logic        STAGE4_DATA_VALID;
  logic [31:0] STAGE4_DATA;
  logic        WB_VALID;
  logic [4:0]  WB_REG_ADDR;
  logic [31:0] WB_DATA;
  logic [1:0]  REQ_VALID;
  logic [9:0]  REQ_REG_ADDR;
  logic [1:0]  FWD_HIT;
  logic [63:0] FWD_DATA;
  logic        LOAD_USE_STALL;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         check_en;
  int           n_tests;
  int           n_fail;

  stage4_forward_buffer #(
    .XLEN       (32),
    .REG_ADDR_W (5),
    .NUM_PORTS  (2),
    .DEPTH      (4)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .FLUSH             (FLUSH),
    .STAGE4_MEM_READ   (STAGE4_MEM_READ),
    .STAGE4_REG_ADDR   (STAGE4_REG_ADDR),
    .STAGE4_DATA_VALID (STAGE4_DATA_VALID),
    .STAGE4_DATA       (STAGE4_DATA),
    .WB_VALID          (WB_VALID),
    .WB_REG_ADDR       (WB_REG_ADDR),
    .WB_DATA           (WB_DATA),
    .REQ_VALID         (REQ_VALID),
    .REQ_REG_ADDR      (REQ_REG_ADDR),
    .FWD_HIT           (FWD_HIT),
    .FWD_DATA          (FWD_DATA),
    .LOAD_USE_STALL    (LOAD_USE_STALL)
  );

  // clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
    check_en = 1'b0;
  endtask

  task automatic idle();
    STALL             = 1'b0;
    FLUSH             = 1'b0;
    STAGE4_MEM_READ   = 1'b0;
    STAGE4_REG_ADDR   = '0;
    STAGE4_DATA_VALID = 1'b0;
    STAGE4_DATA       = '0;
    WB_VALID          = 1'b0;
    WB_REG_ADDR       = '0;
    WB_DATA           = '0;
    REQ_VALID         = '0;
    REQ_REG_ADDR      = '0;
  endtask

  task automatic ld(input logic [4:0] addr, input logic dv, input logic [31:0] data);
    STAGE4_MEM_READ   = 1'b1;
    STAGE4_REG_ADDR   = addr;
    STAGE4_DATA_VALID = dv;
    STAGE4_DATA       = data;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    WB_VALID    = 1'b1;
    WB_REG_ADDR = addr;
    WB_DATA     = data;
  endtask

  task automatic req(input logic [1:0] rv, input logic [4:0] a0, input logic [4:0] a1);
    REQ_VALID    = rv;
    REQ_REG_ADDR = {a1, a0};
  endtask

  task automatic expect_out(input string name, input logic st, input logic [1:0] hit,
                            input logic [31:0] d1, input logic [31:0] d0);
    exp_q.push_back({st, hit, d1, d0});
    name_q.push_back(name);
    check_en = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    string        nm;
    if (check_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor: output presented with no expected entry");
      end else begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        got_v = {LOAD_USE_STALL, FWD_HIT, FWD_DATA};
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL %s: got stall=%b hit=%b d1=%h d0=%h, expected stall=%b hit=%b d1=%h d0=%h",
                   nm, got_v[66], got_v[65:64], got_v[63:32], got_v[31:0],
                   exp_v[66], exp_v[65:64], exp_v[63:32], exp_v[31:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    check_en = 1'b0;
    RESET    = 1'b0;
    idle();

    // reset forces outputs low even with live bypass inputs
    tick(); wb(5'd5, 32'h99); ld(5'd5, 1'b1, 32'h77); req(2'b11, 5'd5, 5'd5);
    expect_out("reset_forced", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); idle(); RESET = 1'b1;
    tick(); idle(); req(2'b01, 5'd5, 5'd0);
    expect_out("empty_after_reset", 1'b0, 2'b00, 32'h0, 32'h0);

    // load-use stall for three cycles, then the data returns
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); ld(5'd5, 1'b0, 32'h0); req(2'b01, 5'd5, 5'd0);
      expect_out("ld_pending", 1'b1, 2'b00, 32'h0, 32'h0);
    end
    tick(); idle(); ld(5'd5, 1'b1, 32'hDEADBEEF); req(2'b01, 5'd5, 5'd0);
    expect_out("ld_return", 1'b0, 2'b01, 32'h0, 32'hDEADBEEF);
    tick(); idle(); ld(5'd5, 1'b0, 32'h0); wb(5'd5, 32'hDEADBEEF); req(2'b01, 5'd5, 5'd0);
    expect_out("ld_hold_at_wb", 1'b0, 2'b01, 32'h0, 32'hDEADBEEF);
    tick(); idle(); req(2'b01, 5'd5, 5'd0);
    expect_out("ld_in_history", 1'b0, 2'b01, 32'h0, 32'hDEADBEEF);

    // load data returns under stall and is held until an unstalled writeback
    tick(); idle(); STALL = 1'b1; ld(5'd9, 1'b1, 32'h1234); req(2'b01, 5'd9, 5'd0);
    expect_out("ld_under_stall", 1'b0, 2'b01, 32'h0, 32'h1234);
    tick(); idle(); STALL = 1'b1; ld(5'd9, 1'b0, 32'h0); req(2'b01, 5'd9, 5'd0);
    expect_out("hold_fwd", 1'b0, 2'b01, 32'h0, 32'h1234);
    tick(); idle(); STALL = 1'b1; ld(5'd9, 1'b0, 32'h0); wb(5'd9, 32'h1234); req(2'b01, 5'd9, 5'd0);
    expect_out("hold_kept_stall", 1'b0, 2'b01, 32'h0, 32'h1234);
    tick(); idle(); ld(5'd9, 1'b0, 32'h0); wb(5'd9, 32'h1234); req(2'b01, 5'd9, 5'd0);
    expect_out("hold_at_wb", 1'b0, 2'b01, 32'h0, 32'h1234);
    tick(); idle(); ld(5'd9, 1'b0, 32'h0); req(2'b01, 5'd9, 5'd0);
    expect_out("hold_cleared", 1'b1, 2'b00, 32'h0, 32'h0);
    tick(); idle(); req(2'b01, 5'd9, 5'd0);
    expect_out("wb9_in_history", 1'b0, 2'b01, 32'h0, 32'h1234);

    // youngest duplicate wins, then eviction by wrap
    tick(); idle(); wb(5'd7, 32'hA);
    tick(); idle(); wb(5'd7, 32'hB); req(2'b11, 5'd7, 5'd7);
    expect_out("wb_bypass", 1'b0, 2'b11, 32'hB, 32'hB);
    tick(); idle();
    tick(); idle(); req(2'b01, 5'd7, 5'd0);
    expect_out("youngest", 1'b0, 2'b01, 32'h0, 32'hB);
    for (int i = 0; i < 5; i++) begin
      tick(); idle(); wb(5'(10 + i), 32'h100 + 32'(i));
    end
    tick(); idle(); req(2'b11, 5'd7, 5'd11);
    expect_out("x7_evicted", 1'b0, 2'b10, 32'h101, 32'h0);

    // x0 is never forwarded nor recorded
    tick(); idle(); wb(5'd0, 32'hFFFF); req(2'b11, 5'd0, 5'd0);
    expect_out("x0_req", 1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); wb(5'(15 + i), 32'h200 + 32'(i));
    end
    tick(); idle(); req(2'b11, 5'd14, 5'd17);
    expect_out("x0_not_written", 1'b0, 2'b11, 32'h202, 32'h104);

    // independent ports: one stalls on a load, the other hits in the history
    tick(); idle(); wb(5'd4, 32'h55);
    tick(); idle(); ld(5'd3, 1'b0, 32'h0); req(2'b11, 5'd3, 5'd4);
    expect_out("mixed_ports", 1'b1, 2'b10, 32'h55, 32'h0);

    // flush clears the history and the capture register
    tick(); idle(); ld(5'd21, 1'b1, 32'h21);
    tick(); idle(); FLUSH = 1'b1; wb(5'd20, 32'h77); req(2'b01, 5'd4, 5'd0);
    expect_out("flush_cycle_live", 1'b0, 2'b01, 32'h0, 32'h55);
    tick(); idle(); req(2'b11, 5'd4, 5'd20);
    expect_out("after_flush_miss", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); idle(); ld(5'd21, 1'b0, 32'h0); req(2'b01, 5'd21, 5'd0);
    expect_out("hold_flushed", 1'b1, 2'b00, 32'h0, 32'h0);

    // reset in the middle of a load and release while stalled
    tick(); idle(); wb(5'd22, 32'h2222);
    tick(); idle(); ld(5'd22, 1'b0, 32'h0); req(2'b01, 5'd22, 5'd0);
    expect_out("pre_reset_stall", 1'b1, 2'b00, 32'h0, 32'h0);
    tick(); idle(); RESET = 1'b0; ld(5'd22, 1'b1, 32'h3333); wb(5'd23, 32'h44); req(2'b11, 5'd22, 5'd23);
    expect_out("reset_mid_load", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); idle(); STALL = 1'b1; ld(5'd22, 1'b0, 32'h0); req(2'b01, 5'd22, 5'd0);
    expect_out("reset_held", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); idle(); RESET = 1'b1; STALL = 1'b1; req(2'b11, 5'd22, 5'd23);
    expect_out("reset_release_miss", 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); idle(); STALL = 1'b1; ld(5'd22, 1'b0, 32'h0); req(2'b01, 5'd22, 5'd0);
    expect_out("no_stale_hold", 1'b1, 2'b00, 32'h0, 32'h0);

    tick(); idle();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
